mem_bank_ctrl: RTL and testbench

Bank-switch controller that drives the load side of the memory bank register: it generates the one-cycle load enable and new bank value from CPU bank commands. Supports plain set plus save/restore through a small bank stack for calls and interrupts. Every switch is deferred to the next instruction boundary so the instruction in flight completes in the old bank. Keeps a shadow copy of the committed bank.

---
 rtl/mem_bank_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_bank_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_ctrl.sv
// mem_bank_ctrl: bank-switch controller for the memory bank register.
// Bank commands are accepted in IDLE, and any resulting switch is held in
// PENDING until the next instruction boundary. At that boundary a one-cycle
// load pulse (bank_ce) is issued together with the new bank value.
// PUSH_SET and POP save and restore the committed bank through a LIFO stack,
// which is used for calls and interrupts.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE, so at most one switch is outstanding. The
// requester may hold cmd_valid high while PENDING; that command is taken on
// the first edge after the controller returns to IDLE.
module mem_bank_ctrl #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [WIDTH-1:0]           cmd_bank,
    input  logic                       instr_end,
    output logic                       bank_ce,
    output logic [WIDTH-1:0]           bank_new,
    output logic [WIDTH-1:0]           bank_cur,
    output logic                       pending,
    output logic [$clog2(DEPTH+1)-1:0] stack_cnt,
    output logic                       err_ovf,
    output logic                       err_unf,
    input  logic                       err_clr
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] OP_SET      = 2'b00;
    localparam logic [1:0] OP_PUSH_SET = 2'b01;
    localparam logic [1:0] OP_POP      = 2'b10;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  target_q, target_d;
    logic [WIDTH-1:0]  bank_cur_q, bank_cur_d;
    logic [WIDTH-1:0]  bank_new_q, bank_new_d;
    logic              bank_ce_q, bank_ce_d;
    logic [CNT_W-1:0]  stack_cnt_q, stack_cnt_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_unf_q, err_unf_d;
    logic [WIDTH-1:0]  stack_q [DEPTH];
    logic [WIDTH-1:0]  stack_d [DEPTH];

    logic              accept;
    logic              commit;
    logic              stack_full;
    logic              stack_empty;
    logic              do_switch;
    logic [PTR_W-1:0]  push_ptr;
    logic [PTR_W-1:0]  top_ptr;

    assign accept      = cmd_valid && cmd_ready;
    assign commit      = (state_q == S_PENDING) && instr_end;
    assign stack_full  = (stack_cnt_q == DEPTH_C);
    assign stack_empty = (stack_cnt_q == '0);
    assign push_ptr    = PTR_W'(stack_cnt_q);
    assign top_ptr     = PTR_W'(stack_cnt_q - CNT_W'(1));

    // Decide whether the accepted command produces a switch. Error cases and
    // NOP are consumed in IDLE without changing the bank.
    always_comb begin
        do_switch = 1'b0;
        if (accept) begin
            unique case (cmd_op)
                OP_SET:      do_switch = 1'b1;
                OP_PUSH_SET: do_switch = !stack_full;
                OP_POP:      do_switch = !stack_empty;
                default:     do_switch = 1'b0;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: the switch waits for an instruction boundary sampled in PENDING.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (do_switch) state_d = S_PENDING;
            S_PENDING: if (instr_end) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM outputs are decoded directly from the state.
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        pending   = (state_q == S_PENDING);
    end

    // Datapath next values: target, stack, committed bank, load pulse, errors.
    always_comb begin
        target_d    = target_q;
        bank_cur_d  = bank_cur_q;
        bank_new_d  = bank_new_q;
        bank_ce_d   = commit;
        stack_cnt_d = stack_cnt_q;
        stack_d     = stack_q;
        err_ovf_d   = err_clr ? 1'b0 : err_ovf_q;
        err_unf_d   = err_clr ? 1'b0 : err_unf_q;

        if (commit) begin
            bank_cur_d = target_q;
            bank_new_d = target_q;
        end

        if (accept) begin
            unique case (cmd_op)
                OP_SET: target_d = cmd_bank;
                OP_PUSH_SET: begin
                    if (stack_full) begin
                        err_ovf_d = 1'b1;
                    end else begin
                        // bank_cur is already final: no switch is outstanding in IDLE.
                        stack_d[push_ptr] = bank_cur_q;
                        stack_cnt_d       = stack_cnt_q + CNT_W'(1);
                        target_d          = cmd_bank;
                    end
                end
                OP_POP: begin
                    if (stack_empty) begin
                        err_unf_d = 1'b1;
                    end else begin
                        target_d    = stack_q[top_ptr];
                        stack_cnt_d = stack_cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Control and bank registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q    <= '0;
            bank_cur_q  <= '0;
            bank_new_q  <= '0;
            bank_ce_q   <= 1'b0;
            stack_cnt_q <= '0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
        end else begin
            target_q    <= target_d;
            bank_cur_q  <= bank_cur_d;
            bank_new_q  <= bank_new_d;
            bank_ce_q   <= bank_ce_d;
            stack_cnt_q <= stack_cnt_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
        end
    end

    // Stack storage needs no reset: only entries below stack_cnt are ever read.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign bank_ce   = bank_ce_q;
    assign bank_new  = bank_new_q;
    assign bank_cur  = bank_cur_q;
    assign stack_cnt = stack_cnt_q;
    assign err_ovf   = err_ovf_q;
    assign err_unf   = err_unf_q;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// tb_mem_bank_ctrl: directed and randomized stimulus for mem_bank_ctrl.
// Outputs are checked after every edge against a behavioural model that keeps
// the bank stack in a queue.
module tb_mem_bank_ctrl;

    localparam int WIDTH = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_SET  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_bank;
    logic             instr_end;
    logic             bank_ce;
    logic [WIDTH-1:0] bank_new;
    logic [WIDTH-1:0] bank_cur;
    logic             pending;
    logic [CW-1:0]    stack_cnt;
    logic             err_ovf;
    logic             err_unf;
    logic             err_clr;

    always #5 clk = ~clk;

    mem_bank_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_bank  (cmd_bank),
        .instr_end (instr_end),
        .bank_ce   (bank_ce),
        .bank_new  (bank_new),
        .bank_cur  (bank_cur),
        .pending   (pending),
        .stack_cnt (stack_cnt),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf),
        .err_clr   (err_clr)
    );

    // ---------------- reference model ----------------
    int               n_vec = 0;
    int               n_err = 0;
    int               n_pulse = 0;
    int               m_stack[$];
    int               m_cur, m_new, m_tgt;
    bit               m_pend, m_ce, m_ovf, m_unf;

    task automatic model_reset();
        m_stack.delete();
        m_cur  = 0;
        m_new  = 0;
        m_tgt  = 0;
        m_pend = 0;
        m_ce   = 0;
        m_ovf  = 0;
        m_unf  = 0;
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input bit v, input logic [1:0] op, input int b,
                              input bit ie, input bit clr);
        bit ovf_ev = 0;
        bit unf_ev = 0;
        m_ce = 0;
        if (m_pend) begin
            if (ie) begin
                m_cur  = m_tgt;
                m_new  = m_tgt;
                m_ce   = 1;
                m_pend = 0;
            end
        end else if (v) begin
            case (op)
                OP_SET: begin
                    m_tgt  = b;
                    m_pend = 1;
                end
                OP_PUSH: begin
                    if (m_stack.size() >= DEPTH) ovf_ev = 1;
                    else begin
                        m_stack.push_back(m_cur);
                        m_tgt  = b;
                        m_pend = 1;
                    end
                end
                OP_POP: begin
                    if (m_stack.size() == 0) unf_ev = 1;
                    else begin
                        m_tgt  = m_stack.pop_back();
                        m_pend = 1;
                    end
                end
                default: ;
            endcase
        end
        if (clr) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (ovf_ev) m_ovf = 1;
        if (unf_ev) m_unf = 1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("cmd_ready", 32'(cmd_ready), 32'(!m_pend));
        check("pending",   32'(pending),   32'(m_pend));
        check("bank_ce",   32'(bank_ce),   32'(m_ce));
        check("bank_new",  32'(bank_new),  32'(m_new));
        check("bank_cur",  32'(bank_cur),  32'(m_cur));
        check("stack_cnt", 32'(stack_cnt), 32'(m_stack.size()));
        check("err_ovf",   32'(err_ovf),   32'(m_ovf));
        check("err_unf",   32'(err_unf),   32'(m_unf));
        if (bank_ce === 1'b1) n_pulse++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit v, input logic [1:0] op, input int b,
                        input bit ie, input bit clr);
        @(negedge clk);
        cmd_valid = v;
        cmd_op    = op;
        cmd_bank  = WIDTH'(b);
        instr_end = ie;
        err_clr   = clr;
        model_edge(v, op, b, ie, clr);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, OP_NOP, 0, 0, 0);
    endtask

    // Issue a command, then commit it at the following instruction boundary.
    task automatic cmd_commit(input logic [1:0] op, input int b);
        step(1, op, b, 0, 0);
        step(0, OP_NOP, 0, 1, 0);
        step(0, OP_NOP, 0, 0, 0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        cmd_valid = 0;
        instr_end = 0;
        err_clr   = 0;
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1;
    endtask

    // ---------------- stimulus ----------------
    int pulses_before;

    initial begin
        rst_n     = 0;
        cmd_valid = 0;
        cmd_op    = OP_NOP;
        cmd_bank  = '0;
        instr_end = 0;
        err_clr   = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1;

        // SET 2, boundary three cycles later.
        step(1, OP_SET, 2, 0, 0);
        idle(2);
        step(0, OP_NOP, 0, 1, 0);
        idle(2);

        // SET 1 / PUSH_SET 3 / POP, each committed.
        pulses_before = n_pulse;
        cmd_commit(OP_SET, 1);
        cmd_commit(OP_PUSH, 3);
        cmd_commit(OP_POP, 0);
        check("three_pulses", 32'(n_pulse - pulses_before), 32'd3);

        // Overflow on the fifth push, then drain, then clear together with underflow.
        for (int i = 0; i < 5; i++) cmd_commit(OP_PUSH, i);
        for (int i = 0; i < 4; i++) cmd_commit(OP_POP, 0);
        step(1, OP_POP, 0, 0, 1);
        step(0, OP_NOP, 0, 0, 1);

        // Accept on the same edge as instr_end, hold cmd_valid during PENDING.
        step(1, OP_SET, 1, 1, 0);
        step(1, OP_SET, 2, 0, 0);
        step(1, OP_SET, 2, 1, 0);
        step(1, OP_SET, 2, 0, 0);
        step(0, OP_NOP, 0, 1, 0);
        idle(1);

        // Reset while PENDING drops the switch.
        step(1, OP_PUSH, 1, 0, 0);
        step(1, OP_SET, 3, 0, 0);
        step(1, OP_SET, 3, 0, 0);
        async_reset();
        step(0, OP_NOP, 0, 1, 0);
        step(0, OP_NOP, 0, 1, 0);

        // NOP and instr_end in IDLE.
        step(1, OP_NOP, 3, 1, 0);
        step(0, OP_NOP, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            else step($urandom_range(0, 1) == 1,
                      2'($urandom_range(0, 3)),
                      int'($urandom_range(0, (1 << WIDTH) - 1)),
                      $urandom_range(0, 2) == 0,
                      $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
